// File: rtl/mofn_scan_display.sv
// Registered 2-of-5 validator/decoder driving a multiplexed 7-segment display,
// an LED column strip and a saturating error counter.
module mofn_scan_display #(
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 1000,
   parameter int WEIGHT   = 0,
   parameter int ERR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        code_in,
   input  logic              code_vld,
   output logic [6:0]        seg_n,
   output logic [DIGITS-1:0] dig_n,
   output logic              dot_n,
   output logic [4:0]        col,
   output logic              err,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [3:0]        last_val
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(SCAN_DIV);

   function automatic logic [2:0] popcount5(input logic [4:0] w);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 5; i++) begin
         n = n + {2'b00, w[i]};
      end
      return n;
   endfunction

   // Weighted sum of set bits; the 11 produced by the top two weights encodes zero.
   function automatic logic [3:0] decode(input logic [4:0] w);
      logic [3:0] sum;
      sum = 4'd0;
      if (WEIGHT == 0) begin
         if (w[4]) sum = sum + 4'd7;
         if (w[3]) sum = sum + 4'd4;
         if (w[2]) sum = sum + 4'd2;
         if (w[1]) sum = sum + 4'd1;
      end else begin
         if (w[4]) sum = sum + 4'd1;
         if (w[3]) sum = sum + 4'd2;
         if (w[2]) sum = sum + 4'd4;
         if (w[1]) sum = sum + 4'd7;
      end
      if (sum == 4'd11) begin
         sum = 4'd0;
      end
      return sum;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'd0:    p = 7'h7E;
         4'd1:    p = 7'h30;
         4'd2:    p = 7'h6D;
         4'd3:    p = 7'h79;
         4'd4:    p = 7'h33;
         4'd5:    p = 7'h5B;
         4'd6:    p = 7'h5F;
         4'd7:    p = 7'h70;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h7B;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   logic [3:0]        pos_r [DIGITS];
   logic [DIGITS-1:0] full_r;
   logic [PW-1:0]     pre_r;
   logic [IW-1:0]     idx_r;
   logic              code_ok_s;
   logic [3:0]        code_val_s;
   logic [6:0]        seg_s;
   logic [DIGITS-1:0] dig_s;

   // Decode the incoming word and select the pattern for the current scan slot.
   always_comb begin
      code_ok_s  = (popcount5(code_in) == 3'd2);
      code_val_s = decode(code_in);
      dig_s      = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_r);
      if (full_r[idx_r]) begin
         seg_s = ~seg7(pos_r[idx_r]);
      end else begin
         seg_s = 7'h7F;
      end
   end

   // Accept path: shift buffer, last valid word and error bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            pos_r[i] <= 4'd0;
         end
         full_r   <= '0;
         col      <= 5'd0;
         err      <= 1'b0;
         err_cnt  <= '0;
         last_val <= 4'd0;
      end else if (code_vld) begin
         if (code_ok_s) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
               pos_r[i]  <= pos_r[i-1];
               full_r[i] <= full_r[i-1];
            end
            pos_r[0]  <= code_val_s;
            full_r[0] <= 1'b1;
            last_val  <= code_val_s;
            col       <= code_in;
            err       <= 1'b0;
         end else begin
            err <= 1'b1;
            if (err_cnt != {ERR_W{1'b1}}) begin
               err_cnt <= err_cnt + ERR_W'(1);
            end
         end
      end
   end

   // Slot prescaler and scan index; accepts never disturb the scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_r <= '0;
         idx_r <= '0;
      end else if (pre_r == PW'(SCAN_DIV - 1)) begin
         pre_r <= '0;
         if (idx_r == IW'(DIGITS - 1)) begin
            idx_r <= '0;
         end else begin
            idx_r <= idx_r + IW'(1);
         end
      end else begin
         pre_r <= pre_r + PW'(1);
      end
   end

   // Registered display pins, one cycle behind the scan index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_n <= 7'h7F;
         dig_n <= '1;
         dot_n <= 1'b1;
      end else begin
         seg_n <= seg_s;
         dig_n <= dig_s;
         dot_n <= ~(err && (idx_r == '0));
      end
   end

endmodule
